// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the XNOR Fibonacci LFSR random generator:
// draw-engine state encoding, the single-step function and maximal tap masks.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        VALID = 2'd2
    } draw_state_e;

    // Returns {next_state, P}; callers zero-extend narrower states and taps to 32 bits.
    function automatic logic [32:0] lfsr_next(input logic [31:0] state, input logic [31:0] taps);
        logic p;
        p = ~^(state & taps);
        return {state[30:0], p, p};
    endfunction

    // Maximal-length XNOR tap masks, bit i-1 = stage Q[i].
    function automatic logic [31:0] default_taps(input int unsigned w);
        logic [31:0] t;
        case (w)
            32'd3:   t = 32'h0000_0006;
            32'd4:   t = 32'h0000_000C;
            32'd5:   t = 32'h0000_0014;
            32'd6:   t = 32'h0000_0030;
            32'd7:   t = 32'h0000_0060;
            32'd8:   t = 32'h0000_00B8;
            32'd9:   t = 32'h0000_0110;
            32'd10:  t = 32'h0000_0240;
            32'd11:  t = 32'h0000_0500;
            32'd12:  t = 32'h0000_0829;
            32'd13:  t = 32'h0000_100D;
            32'd14:  t = 32'h0000_2015;
            32'd15:  t = 32'h0000_6000;
            32'd16:  t = 32'h0000_D008;
            default: t = 32'h0000_0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/lfsr_rng_if.sv
// Draw-word handshake between the random generator (slave) and its consumer (master).
interface lfsr_rng_if #(
    parameter int OUT_W = 4
);
    logic             rnd_req;
    logic             rnd_valid;
    logic             rnd_ready;
    logic [OUT_W-1:0] rnd_data;

    modport master (
        output rnd_req,
        output rnd_ready,
        input  rnd_valid,
        input  rnd_data
    );

    modport slave (
        input  rnd_req,
        input  rnd_ready,
        output rnd_valid,
        output rnd_data
    );
endinterface

// File: rtl/lfsr_core.sv
// LFSR state register with seed load, all-ones lock-up guard and wrap/seed_err pulses.
// Exposes the feedback bit of the pending step so the draw engine can capture it.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 9,
    parameter logic [WIDTH-1:0] TAPS  = 9'h110
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             wrap,
    output logic             seed_err,
    output logic             p,
    output logic             next_zero
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] next_s;
    logic             bit_out_r;
    logic             wrap_r;
    logic             seed_err_r;
    logic             p_s;
    logic             seed_ones_s;
    logic [32:0]      nxt_raw_s;
    logic             nxt_unused_s;

    assign nxt_raw_s    = lfsr_next(32'(q_r), 32'(TAPS));
    assign nxt_unused_s = ^nxt_raw_s;
    assign seed_ones_s  = &seed;

    // Next state, with an upset all-ones state forced back to all-zeros.
    always_comb begin
        next_s = {WIDTH{1'b0}};
        p_s    = 1'b0;
        if (&q_r) begin
            next_s = {WIDTH{1'b0}};
            p_s    = 1'b0;
        end else begin
            next_s = nxt_raw_s[WIDTH:1];
            p_s    = nxt_raw_s[0];
        end
    end

    // State register; load wins over step, all-ones seeds are rejected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r        <= {WIDTH{1'b0}};
            bit_out_r  <= 1'b0;
            wrap_r     <= 1'b0;
            seed_err_r <= 1'b0;
        end else if (load) begin
            q_r        <= seed_ones_s ? {WIDTH{1'b0}} : seed;
            bit_out_r  <= 1'b0;
            wrap_r     <= 1'b0;
            seed_err_r <= seed_ones_s;
        end else if (step) begin
            q_r        <= next_s;
            bit_out_r  <= p_s;
            wrap_r     <= (next_s == {WIDTH{1'b0}});
            seed_err_r <= 1'b0;
        end else begin
            wrap_r     <= 1'b0;
            seed_err_r <= 1'b0;
        end
    end

    assign q         = q_r;
    assign bit_out   = bit_out_r;
    assign wrap      = wrap_r;
    assign seed_err  = seed_err_r;
    assign p         = p_s;
    assign next_zero = (next_s == {WIDTH{1'b0}});

endmodule

// File: rtl/lfsr_rng.sv
// Pseudo-random generator top: LFSR core plus req/valid draw engine assembling OUT_W bits.
// Optional step counter since last wrap/load/reset is enabled by LFSR_RNG_PERIOD_CNT_EN.
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 9,
    parameter logic [WIDTH-1:0] TAPS  = 9'h110,
    parameter int               OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             wrap,
    output logic             seed_err,
`ifdef LFSR_RNG_PERIOD_CNT_EN
    output logic [WIDTH-1:0] period_cnt,
`endif
    lfsr_rng_if.slave        rnd
);

    localparam int CNT_W = $clog2(OUT_W + 1);

    draw_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [OUT_W-1:0] rnd_data_r;
    logic             rnd_valid_r;
    logic             step_s;
    logic             p_s;
    logic             next_zero_s;
    logic [OUT_W:0]   shift_s;
    logic             shift_unused_s;

    // Free-run steps only while idle; a running draw always steps.
    always_comb begin
        step_s = 1'b0;
        if (state_r == DRAW) begin
            step_s = 1'b1;
        end else if (state_r == IDLE) begin
            step_s = en;
        end else begin
            step_s = 1'b0;
        end
    end

    assign shift_s        = {rnd_data_r, p_s};
    assign shift_unused_s = shift_s[OUT_W];

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (step_s),
        .load      (load),
        .seed      (seed),
        .q         (q),
        .bit_out   (bit_out),
        .wrap      (wrap),
        .seed_err  (seed_err),
        .p         (p_s),
        .next_zero (next_zero_s)
    );

    // Draw FSM: a load mid-draw drops the partial word; a held word survives a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            rnd_data_r  <= {OUT_W{1'b0}};
            rnd_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rnd.rnd_req) begin
                        state_r <= DRAW;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                DRAW: begin
                    if (load) begin
                        state_r <= IDLE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        rnd_data_r <= shift_s[OUT_W-1:0];
                        if (cnt_r == CNT_W'(OUT_W - 1)) begin
                            state_r     <= VALID;
                            rnd_valid_r <= 1'b1;
                            cnt_r       <= {CNT_W{1'b0}};
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                VALID: begin
                    if (rnd.rnd_ready) begin
                        state_r     <= IDLE;
                        rnd_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    rnd_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign rnd.rnd_valid = rnd_valid_r;
    assign rnd.rnd_data  = rnd_data_r;

`ifdef LFSR_RNG_PERIOD_CNT_EN
    logic [WIDTH-1:0] period_cnt_r;

    // Steps since the last wrap, load or reset, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt_r <= {WIDTH{1'b0}};
        end else if (load || (step_s && next_zero_s)) begin
            period_cnt_r <= {WIDTH{1'b0}};
        end else if (step_s && !(&period_cnt_r)) begin
            period_cnt_r <= period_cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign period_cnt = period_cnt_r;
`else
    logic zero_unused_s;
    assign zero_unused_s = next_zero_s;
`endif

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed self-checking bench for lfsr_rng (default 9-bit, taps 9,5, 4-bit draws).
// Also covers period_cnt when built with LFSR_RNG_PERIOD_CNT_EN.
module tb_lfsr_rng;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [8:0] seed;
    logic [8:0] q;
    logic       bit_out;
    logic       wrap;
    logic       seed_err;
`ifdef LFSR_RNG_PERIOD_CNT_EN
    logic [8:0] period_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_rng_if #(.OUT_W(4)) rnd_bus ();

    lfsr_rng #(
        .WIDTH (9),
        .TAPS  (9'h110),
        .OUT_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .seed       (seed),
        .q          (q),
        .bit_out    (bit_out),
        .wrap       (wrap),
        .seed_err   (seed_err),
`ifdef LFSR_RNG_PERIOD_CNT_EN
        .period_cnt (period_cnt),
`endif
        .rnd        (rnd_bus)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [8:0] exp_q [6];
    int wrap_cnt;
    int early_zero;
    int bad_cnt;

    initial begin
        exp_q[0] = 9'h001; exp_q[1] = 9'h003; exp_q[2] = 9'h007;
        exp_q[3] = 9'h00F; exp_q[4] = 9'h01F; exp_q[5] = 9'h03E;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; seed = 9'h000;
        rnd_bus.rnd_req = 1'b0; rnd_bus.rnd_ready = 1'b0;
        repeat (3) tick();
        check_val("rst_q", 32'(q), 32'h0);
        check_val("rst_bit_out", 32'(bit_out), 32'h0);
        check_val("rst_wrap", 32'(wrap), 32'h0);
        check_val("rst_seed_err", 32'(seed_err), 32'h0);
        check_val("rst_valid", 32'(rnd_bus.rnd_valid), 32'h0);
        check_val("rst_data", 32'(rnd_bus.rnd_data), 32'h0);

        // Free run over one full period from reset.
        rst_n = 1'b1; en = 1'b1;
        wrap_cnt = 0; early_zero = 0;
        for (int s = 1; s <= 511; s++) begin
            tick();
            if (wrap === 1'b1) wrap_cnt++;
            if (q == 9'h000 && s < 511) early_zero++;
            if (s <= 6) check_val($sformatf("run_q%0d", s), 32'(q), 32'(exp_q[s-1]));
            if (s == 1) check_val("run_bit1", 32'(bit_out), 32'h1);
            if (s == 6) check_val("run_bit6", 32'(bit_out), 32'h0);
`ifdef LFSR_RNG_PERIOD_CNT_EN
            if (s == 6)   check_val("pcnt_6", 32'(period_cnt), 32'd6);
            if (s == 510) check_val("pcnt_510", 32'(period_cnt), 32'd510);
            if (s == 511) check_val("pcnt_wrap", 32'(period_cnt), 32'd0);
`endif
            if (s == 511) begin
                check_val("wrap_q", 32'(q), 32'h0);
                check_val("wrap_pulse", 32'(wrap), 32'h1);
            end
        end
        en = 1'b0;
        check_val("wrap_count", 32'(wrap_cnt), 32'd1);
        check_val("early_zero", 32'(early_zero), 32'd0);
        tick();
        check_val("wrap_drop", 32'(wrap), 32'h0);

        // Seed loads: all-ones rejected, normal seed taken, zero seed gives no wrap.
        load = 1'b1; seed = 9'h1FF;
        tick();
        load = 1'b0;
        check_val("ld1ff_q", 32'(q), 32'h0);
        check_val("ld1ff_err", 32'(seed_err), 32'h1);
        tick();
        check_val("ld1ff_err_drop", 32'(seed_err), 32'h0);
        load = 1'b1; seed = 9'h0AA;
        tick();
        load = 1'b0;
        check_val("ldaa_q", 32'(q), 32'h0AA);
        check_val("ldaa_err", 32'(seed_err), 32'h0);
        check_val("ldaa_bit", 32'(bit_out), 32'h0);
        load = 1'b1; seed = 9'h000;
        tick();
        load = 1'b0;
        check_val("ld0_q", 32'(q), 32'h0);
        check_val("ld0_wrap", 32'(wrap), 32'h0);

        // Draw from reset: bits 1,1,1,1.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rnd_bus.rnd_req = 1'b1;
        tick();
        rnd_bus.rnd_req = 1'b0;
        bad_cnt = 0;
        for (int i = 2; i <= 5; i++) begin
            if (rnd_bus.rnd_valid !== 1'b0) bad_cnt++;
            tick();
        end
        check_val("draw_early_valid", 32'(bad_cnt), 32'd0);
        check_val("draw1_valid", 32'(rnd_bus.rnd_valid), 32'h1);
        check_val("draw1_data", 32'(rnd_bus.rnd_data), 32'hF);
        check_val("draw1_q", 32'(q), 32'h00F);
`ifdef LFSR_RNG_PERIOD_CNT_EN
        check_val("pcnt_draw", 32'(period_cnt), 32'd4);
`endif
        // Hold with en and rnd_req high: both must be ignored in VALID.
        en = 1'b1; rnd_bus.rnd_req = 1'b1;
        bad_cnt = 0;
        repeat (10) begin
            tick();
            if (rnd_bus.rnd_valid !== 1'b1 || rnd_bus.rnd_data !== 4'hF || q !== 9'h00F) bad_cnt++;
        end
        check_val("draw1_hold", 32'(bad_cnt), 32'd0);
        en = 1'b0; rnd_bus.rnd_req = 1'b0;
        rnd_bus.rnd_ready = 1'b1;
        tick();
        rnd_bus.rnd_ready = 1'b0;
        check_val("draw1_accept", 32'(rnd_bus.rnd_valid), 32'h0);

        // Second draw from q=0x00F: bits 1,0,0,0.
        rnd_bus.rnd_req = 1'b1;
        tick();
        rnd_bus.rnd_req = 1'b0;
        repeat (4) tick();
        check_val("draw2_valid", 32'(rnd_bus.rnd_valid), 32'h1);
        check_val("draw2_data", 32'(rnd_bus.rnd_data), 32'h8);
        check_val("draw2_q", 32'(q), 32'h0F8);
        rnd_bus.rnd_ready = 1'b1;
        tick();
        rnd_bus.rnd_ready = 1'b0;
        check_val("draw2_accept", 32'(rnd_bus.rnd_valid), 32'h0);

        // Load during DRAW aborts the draw.
        rnd_bus.rnd_req = 1'b1;
        tick();
        rnd_bus.rnd_req = 1'b0;
        tick();
        load = 1'b1; seed = 9'h055;
        tick();
        load = 1'b0;
        check_val("abort_q", 32'(q), 32'h055);
        bad_cnt = 0;
        repeat (8) begin
            tick();
            if (rnd_bus.rnd_valid !== 1'b0 || q !== 9'h055) bad_cnt++;
        end
        check_val("abort_idle", 32'(bad_cnt), 32'd0);

        // Asynchronous reset in the middle of a draw.
        rnd_bus.rnd_req = 1'b1;
        tick();
        rnd_bus.rnd_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_val("arst_q", 32'(q), 32'h0);
        check_val("arst_bit_out", 32'(bit_out), 32'h0);
        check_val("arst_wrap", 32'(wrap), 32'h0);
        check_val("arst_seed_err", 32'(seed_err), 32'h0);
        check_val("arst_valid", 32'(rnd_bus.rnd_valid), 32'h0);
        check_val("arst_data", 32'(rnd_bus.rnd_data), 32'h0);
`ifdef LFSR_RNG_PERIOD_CNT_EN
        check_val("arst_pcnt", 32'(period_cnt), 32'd0);
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
